mmm_engine: RTL and testbench

- Responder end of the pipeline's matrix-multiply interface. The pipeline issues start_mmm to launch an operation and wait_mmm_finish to block until it completes; this block answers with mmm_stall.
- On start it computes C = A x B for NxN signed 32-bit matrices held in data memory, using its own dedicated memory port.
- Sits beside the MEM stage. The start and wait strobes come from the pipeline registers. mmm_stall feeds the pipeline's hold logic combinationally in the same cycle.

---
 rtl/mmm_pkg.sv | 17 +
 rtl/mmm_if.sv | 31 +++
 rtl/mmm_mac.sv | 40 ++++
 rtl/mmm_engine.sv | 155 +++++++++++++++
 tb/tb_mmm_engine.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mmm_pkg.sv
// Shared types and constants for the matrix-multiply engine.
package mmm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_MAC,
        S_WR,
        S_FIN
    } mmm_state_t;

    localparam int MMM_WORD_BYTES = 4;
    localparam int MMM_N          = 4;
    localparam int MMM_WIDTH      = 32;

endpackage

// File: rtl/mmm_if.sv
// Pipeline control strobes plus the engine's dedicated data-memory port.
interface mmm_if
    import mmm_pkg::*;
#(
    parameter int WIDTH = MMM_WIDTH
);
    logic             start_mmm;
    logic             wait_mmm_finish;
    logic [WIDTH-1:0] a_base;
    logic [WIDTH-1:0] b_base;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rd_data;
    logic [WIDTH-1:0] mem_wr_data;
    logic             mem_wr_en;
    logic             mmm_stall;
    logic             busy;
    logic             done;
    logic             overrun;

    // The engine side.
    modport slave (
        input  start_mmm, wait_mmm_finish, a_base, b_base, mem_rd_data,
        output mem_addr, mem_wr_data, mem_wr_en, mmm_stall, busy, done, overrun
    );

    // The pipeline / memory side.
    modport master (
        output start_mmm, wait_mmm_finish, a_base, b_base, mem_rd_data,
        input  mem_addr, mem_wr_data, mem_wr_en, mmm_stall, busy, done, overrun
    );
endinterface

// File: rtl/mmm_mac.sv
// Multiply-accumulate: acc += a * b, signed, keeping the low WIDTH bits.
module mmm_mac
    import mmm_pkg::*;
#(
    parameter int WIDTH = MMM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc
);
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] prod;

    // Low half of a two's-complement product is identical for signed/unsigned.
    assign prod = WIDTH'($signed(a) * $signed(b));

    always_comb begin
        acc_next = acc_reg;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc_reg + prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign acc = acc_reg;
endmodule

// File: rtl/mmm_engine.sv
// Sequential NxN matrix multiply C = A x B over a single memory port,
// one MAC per element term, C stored directly after B.
module mmm_engine
    import mmm_pkg::*;
#(
    parameter int WIDTH = MMM_WIDTH,
    parameter int N     = MMM_N
) (
    input  logic  clk,
    input  logic  reset,
    mmm_if.slave  bus
);
    localparam int               IDX_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST       = IDX_W'(N - 1);
    localparam logic [WIDTH-1:0] N_W        = WIDTH'(N);
    localparam logic [WIDTH-1:0] WORD_BYTES = WIDTH'(MMM_WORD_BYTES);
    localparam logic [WIDTH-1:0] MAT_BYTES  = WIDTH'(MMM_WORD_BYTES * N * N);

    mmm_state_t       state_reg, state_next;
    logic [IDX_W-1:0] i_reg, i_next;
    logic [IDX_W-1:0] j_reg, j_next;
    logic [IDX_W-1:0] k_reg, k_next;
    logic [WIDTH-1:0] a_base_reg, b_base_reg, c_base_reg;
    logic [WIDTH-1:0] a_elem_reg;
    logic             overrun_reg;

    logic             base_load;
    logic             a_load;
    logic             acc_clr;
    logic             acc_en;
    logic             in_flight;
    logic [WIDTH-1:0] acc;

    function automatic logic [WIDTH-1:0] elem_addr(
        input logic [WIDTH-1:0] base,
        input logic [IDX_W-1:0] row,
        input logic [IDX_W-1:0] col
    );
        return base + (WIDTH'(row) * N_W + WIDTH'(col)) * WORD_BYTES;
    endfunction

    mmm_mac #(.WIDTH(WIDTH)) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (acc_clr),
        .en    (acc_en),
        .a     (a_elem_reg),
        .b     (bus.mem_rd_data),
        .acc   (acc)
    );

    always_comb begin
        state_next    = state_reg;
        i_next        = i_reg;
        j_next        = j_reg;
        k_next        = k_reg;
        base_load     = 1'b0;
        a_load        = 1'b0;
        acc_clr       = 1'b0;
        acc_en        = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wr_en = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start_mmm) begin
                    base_load  = 1'b1;
                    acc_clr    = 1'b1;
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    state_next = S_RD_A;
                end
            end
            S_RD_A: begin
                bus.mem_addr = elem_addr(a_base_reg, i_reg, k_reg);
                state_next   = S_RD_B;
            end
            S_RD_B: begin
                // A element requested last cycle arrives now.
                bus.mem_addr = elem_addr(b_base_reg, k_reg, j_reg);
                a_load       = 1'b1;
                state_next   = S_MAC;
            end
            S_MAC: begin
                acc_en = 1'b1;
                if (k_reg == LAST) begin
                    state_next = S_WR;
                end else begin
                    k_next     = k_reg + IDX_W'(1);
                    state_next = S_RD_A;
                end
            end
            S_WR: begin
                bus.mem_addr  = elem_addr(c_base_reg, i_reg, j_reg);
                bus.mem_wr_en = 1'b1;
                acc_clr       = 1'b1;
                k_next        = '0;
                if (j_reg == LAST) begin
                    j_next = '0;
                    i_next = (i_reg == LAST) ? '0 : i_reg + IDX_W'(1);
                end else begin
                    j_next = j_reg + IDX_W'(1);
                end
                state_next = ((i_reg == LAST) && (j_reg == LAST)) ? S_FIN : S_RD_A;
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            i_reg       <= '0;
            j_reg       <= '0;
            k_reg       <= '0;
            a_base_reg  <= '0;
            b_base_reg  <= '0;
            c_base_reg  <= '0;
            a_elem_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            if (base_load) begin
                a_base_reg <= bus.a_base;
                b_base_reg <= bus.b_base;
                c_base_reg <= bus.b_base + MAT_BYTES;
            end
            if (a_load) begin
                a_elem_reg <= bus.mem_rd_data;
            end
            if (bus.start_mmm && (state_reg != S_IDLE)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // FIN is excluded so a held wait instruction is released as done pulses.
    assign in_flight = (state_reg == S_RD_A) || (state_reg == S_RD_B) ||
                       (state_reg == S_MAC)  || (state_reg == S_WR);

    assign bus.busy        = in_flight;
    assign bus.done        = (state_reg == S_FIN);
    assign bus.overrun     = overrun_reg;
    assign bus.mem_wr_data = acc;
    assign bus.mmm_stall   = bus.wait_mmm_finish & (in_flight | bus.start_mmm);
endmodule

// File: tb/tb_mmm_engine.sv
// Directed bench for mmm_engine: behavioural memory, hand-computed results.
module tb_mmm_engine;
    import mmm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mmm_if #(.WIDTH(32)) bus();

    mmm_engine #(.WIDTH(32), .N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    int          cyc      = 0;
    int          wr_count = 0;
    logic        tb_we    = 1'b0;
    logic [31:0] tb_wa    = '0;
    logic [31:0] tb_wd    = '0;

    int          checks = 0;
    int          errors = 0;
    int          start_cyc;
    int          lat;
    int          wr_base;
    bit          found;
    bit          stall_bad;
    logic [31:0] a_vals [16];
    logic [31:0] b_vals [16];
    logic [31:0] exp_c  [16];

    // Memory: one-cycle read latency; engine writes take priority over loads.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.mem_rd_data <= mem[bus.mem_addr[11:2]];
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wr_data;
            wr_count <= wr_count + 1;
        end else if (tb_we) begin
            mem[tb_wa[11:2]] <= tb_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
        tb_we = 1'b1;
        tb_wa = addr;
        tb_wd = data;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic load_ab();
        for (int e = 0; e < 16; e++) begin
            wr_word(32'h100 + 32'(4 * e), a_vals[e]);
            wr_word(32'h200 + 32'(4 * e), b_vals[e]);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit with_wait);
        @(posedge clk); #1;
        bus.start_mmm = 1'b1;
        bus.a_base    = a;
        bus.b_base    = b;
        if (with_wait) bus.wait_mmm_finish = 1'b1;
        start_cyc = cyc;
        wr_base   = wr_count;
        @(negedge clk);
        if (with_wait) check("stall_start_cycle", 32'(bus.mmm_stall), 32'd1);
        @(posedge clk); #1;
        bus.start_mmm = 1'b0;
    endtask

    task automatic wait_done(input bit track_stall);
        found     = 1'b0;
        stall_bad = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.done) begin
                found = 1'b1;
                break;
            end
            if (track_stall && (bus.mmm_stall !== 1'b1)) stall_bad = 1'b1;
        end
        lat = cyc - start_cyc;
        check("done_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_c(input string tag, input logic [31:0] c_base);
        for (int e = 0; e < 16; e++) begin
            check($sformatf("%s_c[%0d]", tag, e), mem[(c_base[11:2]) + 10'(e)], exp_c[e]);
        end
    endtask

    initial begin
        reset               = 1'b1;
        bus.start_mmm       = 1'b0;
        bus.wait_mmm_finish = 1'b0;
        bus.a_base          = '0;
        bus.b_base          = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and idle wait
        @(negedge clk);
        check("rst_busy",    32'(bus.busy),      32'd0);
        check("rst_done",    32'(bus.done),      32'd0);
        check("rst_wr_en",   32'(bus.mem_wr_en), 32'd0);
        check("rst_addr",    bus.mem_addr,       32'd0);
        check("rst_overrun", 32'(bus.overrun),   32'd0);
        check("rst_wr_data", bus.mem_wr_data,    32'd0);
        bus.wait_mmm_finish = 1'b1;
        #1 check("idle_wait_stall", 32'(bus.mmm_stall), 32'd0);
        bus.wait_mmm_finish = 1'b0;

        // Identity x 1..16, wait held from cycle 5
        for (int e = 0; e < 16; e++) begin
            a_vals[e] = ((e / 4) == (e % 4)) ? 32'd1 : 32'd0;
            b_vals[e] = 32'(e + 1);
            exp_c[e]  = 32'(e + 1);
        end
        load_ab();
        start_op(32'h100, 32'h200, 1'b0);
        @(negedge clk);
        check("ident_busy", 32'(bus.busy), 32'd1);
        wait_until(start_cyc + 5);
        bus.wait_mmm_finish = 1'b1;
        wait_done(1'b1);
        check("ident_latency",  32'(lat),           32'd209);
        check("ident_stall_hold", 32'(stall_bad),   32'd0);
        check("ident_stall_fin", 32'(bus.mmm_stall), 32'd0);
        check("ident_busy_fin", 32'(bus.busy),      32'd0);
        check("ident_writes",   32'(wr_count - wr_base), 32'd16);
        bus.wait_mmm_finish = 1'b0;
        check_c("ident", 32'h240);

        // All 2 x all 3
        for (int e = 0; e < 16; e++) begin
            a_vals[e] = 32'd2;
            b_vals[e] = 32'd3;
            exp_c[e]  = 32'd24;
        end
        load_ab();
        start_op(32'h100, 32'h200, 1'b0);
        wait_done(1'b0);
        check_c("const", 32'h240);

        // Wrapping product
        for (int e = 0; e < 16; e++) begin
            a_vals[e] = 32'd0;
            b_vals[e] = 32'd0;
            exp_c[e]  = 32'd0;
        end
        a_vals[0] = 32'h7FFF_FFFF;
        b_vals[0] = 32'd2;
        exp_c[0]  = 32'hFFFF_FFFE;
        load_ab();
        start_op(32'h100, 32'h200, 1'b0);
        wait_done(1'b0);
        check_c("ovf", 32'h240);

        // All -1 x 1..16, start and wait in the same cycle
        for (int e = 0; e < 16; e++) begin
            a_vals[e] = 32'hFFFF_FFFF;
            b_vals[e] = 32'(e + 1);
            exp_c[e]  = 32'(-(28 + 4 * (e % 4)));
        end
        load_ab();
        start_op(32'h100, 32'h200, 1'b1);
        wait_done(1'b1);
        check("neg_stall_hold", 32'(stall_bad),      32'd0);
        check("neg_stall_fin",  32'(bus.mmm_stall),  32'd0);
        bus.wait_mmm_finish = 1'b0;
        check_c("neg", 32'h240);

        // Second start at cycle 50 is ignored
        for (int e = 0; e < 16; e++) begin
            a_vals[e] = ((e / 4) == (e % 4)) ? 32'd1 : 32'd0;
            b_vals[e] = 32'(e + 1);
            exp_c[e]  = 32'(e + 1);
        end
        load_ab();
        start_op(32'h100, 32'h200, 1'b0);
        wait_until(start_cyc + 50);
        bus.start_mmm = 1'b1;
        bus.a_base    = 32'h300;
        bus.b_base    = 32'h380;
        @(posedge clk); #1;
        bus.start_mmm = 1'b0;
        check("ovr_set", 32'(bus.overrun), 32'd1);
        wait_done(1'b0);
        check("ovr_latency", 32'(lat), 32'd209);
        check("ovr_writes",  32'(wr_count - wr_base), 32'd16);
        check_c("ovr", 32'h240);
        repeat (5) @(posedge clk);
        #1 check("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Reset at cycle 100: seven elements already written, nothing after
        for (int e = 0; e < 16; e++) begin
            a_vals[e] = 32'd2;
            b_vals[e] = 32'(e + 1);
            wr_word(32'h240 + 32'(4 * e), 32'hDEAD_BEEF);
        end
        load_ab();
        start_op(32'h100, 32'h200, 1'b0);
        wait_until(start_cyc + 100);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_busy",    32'(bus.busy),      32'd0);
        check("mid_rst_wr_en",   32'(bus.mem_wr_en), 32'd0);
        check("mid_rst_addr",    bus.mem_addr,       32'd0);
        check("mid_rst_overrun", 32'(bus.overrun),   32'd0);
        repeat (300) @(posedge clk);
        #1;
        check("mid_rst_writes", 32'(wr_count - wr_base), 32'd7);
        check("mid_rst_c00", mem[10'h240 >> 2], 32'd56);
        check("mid_rst_c03", mem[10'h24C >> 2], 32'd80);
        check("mid_rst_c12", mem[10'h258 >> 2], 32'd72);
        check("mid_rst_c13", mem[10'h25C >> 2], 32'hDEAD_BEEF);
        check("mid_rst_c33", mem[10'h27C >> 2], 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
